// File: rtl/adder_pkg.sv
// Shared types for the adder result path.
package adder_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef struct packed {
        logic                   cout;
        logic [ADDER_WIDTH-1:0] sum;
    } adder_result_t;

endpackage

// File: rtl/result_fifo_ctrl.sv
// Pointer/occupancy control for the adder result FIFO.
module result_fifo_ctrl #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [PW-1:0] level
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full;
    logic          empty;

    // Extra MSB on each pointer distinguishes full from empty.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        in_ready  = !full && !rst;
        out_valid = !empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        wr_addr   = wr_ptr_q[AW-1:0];
        rd_addr   = rd_ptr_q[AW-1:0];
        level     = wr_ptr_q - rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/adder_result_buffer.sv
// Registered result stage behind the 4-bit adder: checks each captured
// result against A+B, buffers it, and keeps carry/mismatch statistics.
module adder_result_buffer
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    input  logic [WIDTH-1:0]           SUM,
    input  logic                       COUT,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH:0]             out_result,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           carry_count,
    output logic                       mismatch,
    input  logic                       clr_stats
);

    localparam int AW = $clog2(DEPTH);

    logic          push;
    logic          pop;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    result_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .pop       (pop),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .level     (level)
    );

    logic [WIDTH:0]       mem_q [DEPTH];
    logic [WIDTH:0]       entry_d;
    logic [WIDTH:0]       ref_sum;
    logic                 bad_sum;
    logic [CNT_W-1:0]     carry_count_q, carry_count_d;
    logic                 mismatch_q, mismatch_d;

    always_comb begin
        entry_d = {COUT, SUM};
        ref_sum = {1'b0, A} + {1'b0, B};
        bad_sum = (ref_sum != entry_d);
    end

    // Storage needs no reset; the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_addr] <= entry_d;
        end
    end

    always_comb begin
        carry_count_d = carry_count_q;
        mismatch_d    = mismatch_q;
        if (push && COUT && (carry_count_q != '1)) begin
            carry_count_d = carry_count_q + 1'b1;
        end
        if (push && bad_sum) begin
            mismatch_d = 1'b1;
        end
        if (clr_stats) begin
            carry_count_d = '0;
            mismatch_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_count_q <= '0;
            mismatch_q    <= 1'b0;
        end else begin
            carry_count_q <= carry_count_d;
            mismatch_q    <= mismatch_d;
        end
    end

    always_comb begin
        out_result  = out_valid ? mem_q[rd_addr] : '0;
        carry_count = carry_count_q;
        mismatch    = mismatch_q;
    end

    logic unused_pop;
    assign unused_pop = pop;

endmodule

// File: tb/tb_adder_result_buffer.sv
// Randomized self-checking bench for adder_result_buffer.
module tb_adder_result_buffer;
    import adder_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_stats = 1'b0;
    logic       COUT = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [3:0] SUM = '0;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_result;
    logic [2:0] level;
    logic [7:0] carry_count;
    logic       mismatch;

    adder_result_buffer #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .SUM         (SUM),
        .COUT        (COUT),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .level       (level),
        .carry_count (carry_count),
        .mismatch    (mismatch),
        .clr_stats   (clr_stats)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    adder_result_t q[$];
    int            cc = 0;
    bit            mm = 0;

    function automatic logic [4:0] head();
        if (q.size() == 0) return 5'd0;
        return 5'(q[0]);
    endfunction

    // Reference: a FIFO of accepted results plus arithmetic statistics.
    task automatic tick();
        bit            psh;
        bit            pp;
        adder_result_t e;
        logic [4:0]    r;
        psh = in_valid && !rst && (q.size() < 4);
        pp  = out_ready && (q.size() > 0);
        e   = '{cout: COUT, sum: SUM};
        r   = 5'(A) + 5'(B);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (psh) begin
            q.push_back(e);
            if (r != 5'(e)) mm = 1;
            if (COUT && cc < 255) cc++;
        end
        if (clr_stats) begin
            cc = 0;
            mm = 0;
        end
        #1;
    endtask

    task automatic set_add(input bit good);
        A = 4'($urandom);
        B = 4'($urandom);
        if (good) {COUT, SUM} = 5'(A) + 5'(B);
        else {COUT, SUM} = 5'($urandom);
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (level !== 3'd0) $display("FAIL rst_level got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_result !== 5'd0) $display("FAIL rst_out_result got %h want 0", out_result); else pass_cnt++;
        total_cnt++; if (carry_count !== 8'd0) $display("FAIL rst_carry got %0d want 0", carry_count); else pass_cnt++;
        total_cnt++; if (mismatch !== 1'b0) $display("FAIL rst_mismatch got %b want 0", mismatch); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_single_push();
        A = 4'd3; B = 4'd5; SUM = 4'd8; COUT = 1'b0;
        in_valid = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL no_bypass got %b want 0", out_valid); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_result !== 5'h08) $display("FAIL single_result got %h want 08", out_result); else pass_cnt++;
        total_cnt++; if (level !== 3'd1) $display("FAIL single_level got %0d want 1", level); else pass_cnt++;
        total_cnt++; if (mismatch !== 1'b0) $display("FAIL single_mismatch got %b want 0", mismatch); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (level !== 3'd0) $display("FAIL single_drain got %0d want 0", level); else pass_cnt++;
    endtask

    task automatic test_full();
        in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (4) begin
            set_add(1);
            tick();
        end
        total_cnt++; if (level !== 3'd4) $display("FAIL full_level got %0d want 4", level); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else pass_cnt++;
        set_add(1);
        tick();
        total_cnt++; if (level !== 3'd4) $display("FAIL full_reject got %0d want 4", level); else pass_cnt++;
        set_add(1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        total_cnt++; if (level !== 3'd3) $display("FAIL full_no_passthru got %0d want 3", level); else pass_cnt++;
        repeat (3) begin
            total_cnt++; if (out_result !== head()) $display("FAIL full_order got %h want %h", out_result, head()); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL full_drained got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_carry_mismatch();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        A = 4'd15; B = 4'd1; SUM = 4'd0; COUT = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        total_cnt++; if (out_result !== 5'h10) $display("FAIL carry_result got %h want 10", out_result); else pass_cnt++;
        total_cnt++; if (carry_count !== 8'd1) $display("FAIL carry_count got %0d want 1", carry_count); else pass_cnt++;
        total_cnt++; if (mismatch !== 1'b0) $display("FAIL carry_no_mismatch got %b want 0", mismatch); else pass_cnt++;
        A = 4'd2; B = 4'd2; SUM = 4'd5; COUT = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        total_cnt++; if (mismatch !== 1'b1) $display("FAIL mismatch_set got %b want 1", mismatch); else pass_cnt++;
        total_cnt++; if (out_result !== 5'h05) $display("FAIL mismatch_stored got %h want 05", out_result); else pass_cnt++;
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        total_cnt++; if (mismatch !== 1'b1) $display("FAIL mismatch_sticky got %b want 1", mismatch); else pass_cnt++;
        total_cnt++; if (carry_count !== 8'd1) $display("FAIL carry_hold got %0d want 1", carry_count); else pass_cnt++;
    endtask

    task automatic test_saturate();
        logic [3:0] a;
        logic [3:0] b;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = 4'($urandom_range(8, 15));
            b = 4'($urandom_range(16 - a, 15));
            A = a; B = b;
            {COUT, SUM} = 5'(a) + 5'(b);
            tick();
            total_cnt++; if (carry_count !== 8'(cc)) $display("FAIL sat_step%0d got %0d want %0d", i, carry_count, cc); else pass_cnt++;
        end
        total_cnt++; if (carry_count !== 8'd255) $display("FAIL sat_final got %0d want 255", carry_count); else pass_cnt++;
        A = 4'd15; B = 4'd15; SUM = 4'd0; COUT = 1'b1;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        in_valid = 1'b0;
        total_cnt++; if (carry_count !== 8'd0) $display("FAIL clr_wins_count got %0d want 0", carry_count); else pass_cnt++;
        total_cnt++; if (mismatch !== 1'b0) $display("FAIL clr_wins_mismatch got %b want 0", mismatch); else pass_cnt++;
        repeat (3) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        out_ready = 1'b0;
        repeat (3) begin
            set_add(1);
            tick();
        end
        in_valid = 1'b0;
        total_cnt++; if (level !== 3'd3) $display("FAIL mid_fill got %0d want 3", level); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        q.delete();
        cc = 0;
        mm = 0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (level !== 3'd0) $display("FAIL mid_rst_level got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (out_result !== 5'd0) $display("FAIL mid_rst_result got %h want 0", out_result); else pass_cnt++;
        #2 rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            in_valid = (i < 12);
            out_ready = (i > 1);
            set_add(1);
            #1;
            total_cnt++; if (out_result !== head()) $display("FAIL wrap_order%0d got %h want %h", i, out_result, head()); else pass_cnt++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        total_cnt++; if (level !== 3'd0) $display("FAIL wrap_drain got %0d want 0", level); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 99) == 0);
            set_add($urandom_range(0, 9) != 0);
            #1;
            total_cnt++; if (out_result !== head()) $display("FAIL rnd_result%0d got %h want %h", i, out_result, head()); else pass_cnt++;
            total_cnt++; if (level !== 3'(q.size())) $display("FAIL rnd_level%0d got %0d want %0d", i, level, q.size()); else pass_cnt++;
            total_cnt++; if (level > 3'd4) $display("FAIL rnd_level_max%0d got %0d want <=4", i, level); else pass_cnt++;
            total_cnt++; if (in_ready !== (q.size() < 4)) $display("FAIL rnd_in_ready%0d got %b want %b", i, in_ready, q.size() < 4); else pass_cnt++;
            total_cnt++; if (out_valid !== (q.size() > 0)) $display("FAIL rnd_out_valid%0d got %b want %b", i, out_valid, q.size() > 0); else pass_cnt++;
            total_cnt++; if (carry_count !== 8'(cc)) $display("FAIL rnd_carry%0d got %0d want %0d", i, carry_count, cc); else pass_cnt++;
            total_cnt++; if (mismatch !== mm) $display("FAIL rnd_mismatch%0d got %b want %b", i, mismatch, mm); else pass_cnt++;
            tick();
        end
        in_valid = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b0;
        total_cnt++; if (carry_count !== 8'(cc)) $display("FAIL rnd_carry_end got %0d want %0d", carry_count, cc); else pass_cnt++;
        total_cnt++; if (mismatch !== mm) $display("FAIL rnd_mismatch_end got %b want %b", mismatch, mm); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_carry_mismatch();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adder_result_buffer.md
# adder_result_buffer

Registered result stage directly downstream of the 4-bit binary adder. Captures each `{COUT,SUM}` result with its operands `A`/`B` under a valid/ready handshake, checks arithmetic correctness on capture, and buffers results in a small FIFO for the consumer. Also keeps a saturating carry-out statistic and a sticky mismatch flag for the formal/simulation environment.

## Interface
- `WIDTH`, 4, operand/sum width; result width is `WIDTH+1`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 8, width of `carry_count`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  adder result presented.
- `in_ready`  out  1  buffer can accept.
- `A`, `B`  in  WIDTH  operands that produced the result.
- `SUM`  in  WIDTH  adder sum.
- `COUT`  in  1  adder carry-out.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer takes head.
- `out_result`  out  WIDTH+1  head entry `{COUT,SUM}`.
- `level`  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- `carry_count`  out  CNT_W  accepted entries with `COUT`=1, saturating.
- `mismatch`  out  1  sticky: an accepted result disagreed with `A+B`.
- `clr_stats`  in  1  synchronous clear of `carry_count` and `mismatch`.

## Operation
- Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- `in_ready = !full && !rst`; `out_valid = !empty`; `out_result` = storage at read pointer (0 when empty).
- Occupancy states (derived from `level`): EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH). EMPTY→PARTIAL on push only; PARTIAL→FULL on push-only at DEPTH-1; FULL→PARTIAL on pop; PARTIAL→EMPTY on pop-only at 1; push+pop together holds `level`.
- No bypass: empty buffer never presents a result in the cycle it is pushed.
- FULL: `in_ready`=0; a simultaneous pop in that cycle does not enable a push (no pass-through).
- Pointers are `$clog2(DEPTH)+1` bits, wrap modulo 2·DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
- On each push: reference = zero-extended `A` + zero-extended `B` at WIDTH+1 bits; if ≠ `{COUT,SUM}`, set `mismatch`. The stored entry is always the adder's `{COUT,SUM}`, never the reference.
- On each push with `COUT`=1: `carry_count` increments, holding at 2^CNT_W−1.
- `clr_stats` and a counted push in the same cycle: clear wins (count → 0; `mismatch` → 0 even if this push mismatches).
- Inputs when `in_valid`=0 are don't-care and must not affect any state.

## Timing
- Reset values (asynchronous, immediate): `level`=0, `out_valid`=0, `in_ready`=0 while `rst` high then 1, `out_result`=0, `carry_count`=0, `mismatch`=0, pointers 0. Storage contents need not be cleared.
- Reset mid-operation discards all buffered entries; no pop is reported.
- Push in cycle N → `out_valid`=1 and `out_result` valid in cycle N+1 (latency 1).
- Pop in cycle N → next entry (if any) on `out_result` in cycle N+1.
- `level`, `carry_count`, `mismatch` update on the edge ending the push/pop/clear cycle.
- Sustained throughput: one push and one pop per cycle when PARTIAL.

## Structure
- Shared package `adder_pkg`: `WIDTH` default constant, `adder_result_t` packed struct `{logic cout; logic [WIDTH-1:0] sum;}`.
- One sub-module `result_fifo_ctrl`: pointers, `level`, full/empty, push/pop qualification. Storage array, checker and statistics stay in the top.

## Test plan
- Reset then single push `A`=3, `B`=5, `SUM`=8, `COUT`=0 → next cycle `out_valid`=1, `out_result`=5'h08, `level`=1, `mismatch`=0.
- Push 4 results with `out_ready`=0 → `level`=4, `in_ready`=0; 5th `in_valid` not accepted; pop+`in_valid` same cycle → `level`=3, nothing pushed.
- `A`=15, `B`=1, `SUM`=0, `COUT`=1 → `out_result`=5'h10, `carry_count`=1; then `A`=2, `B`=2, `SUM`=5, `COUT`=0 → `mismatch`=1 and stays 1.
- 300 pushes with `COUT`=1 (`CNT_W`=8), continuous pop → `carry_count` saturates at 255; `clr_stats` with a carry push same cycle → 0.
- Fill 3 entries, assert `rst` mid-cycle → `out_valid`, `level`, `out_result` 0 immediately; after release, order of new pushes preserved across pointer wrap (≥10 push/pop cycles).
- Random `in_valid`/`out_ready` 1000 cycles → output sequence equals accepted sequence, `level` never exceeds 4.
